// File: rtl/fsm_ctrl_pkg.sv
// Shared types for the timed run/stop controller.
// State encodings match the legacy out_signal mapping so downstream decoders are unchanged.
package fsm_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CMD_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STOP  = 2'b10,
    FAULT = 2'b11
  } state_t;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_t;

endpackage

// File: rtl/fsm_ctrl_timed_if.sv
// Host <-> controller bundle: command handshake, liveness/acknowledge inputs, status outputs.
//   master: host side (drives cmd_valid/cmd/heartbeat/fault_clr)
//   slave : controller side (drives cmd_ready/state_out/busy/timeout_flag)
interface fsm_ctrl_timed_if;
  import fsm_ctrl_pkg::*;

  logic               cmd_valid;
  logic [CMD_W-1:0]   cmd;
  logic               cmd_ready;
  logic               heartbeat;
  logic               fault_clr;
  logic [STATE_W-1:0] state_out;
  logic               busy;
  logic               timeout_flag;

  modport master (
    output cmd_valid, cmd, heartbeat, fault_clr,
    input  cmd_ready, state_out, busy, timeout_flag
  );

  modport slave (
    input  cmd_valid, cmd, heartbeat, fault_clr,
    output cmd_ready, state_out, busy, timeout_flag
  );

endinterface

// File: rtl/fsm_timer.sv
// Shared up-counter for the RUN watchdog and the STOP drain phase.
//   clk, reset_n : clock / async active-low reset
//   i_clr        : synchronous clear (wins over enable)
//   i_en         : count enable
//   i_term       : terminal value to compare against
//   o_at_term_c  : combinational, count == i_term
module fsm_timer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [TIMER_W-1:0] i_term,
  output logic               o_at_term_c
);

  logic [TIMER_W-1:0] r_count;

  // Counter never wraps in use: the controller clears it on the terminal compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_at_term_c = (r_count == i_term);

endmodule

// File: rtl/fsm_ctrl_timed.sv
// Run/stop control FSM with command handshake, RUN watchdog, timed STOP drain and latched FAULT.
//   clk, reset_n : clock / async active-low reset
//   bus (slave)  : cmd_valid/cmd/cmd_ready handshake, heartbeat, fault_clr,
//                  state_out/busy/timeout_flag status (cmd_ready is combinational from state)
module fsm_ctrl_timed
  import fsm_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_W     = 16,
  parameter int unsigned RUN_TIMEOUT = 1000,
  parameter int unsigned STOP_HOLD   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  fsm_ctrl_timed_if.slave  bus
);

  localparam longint unsigned TIMER_SPAN = 64'd1 << TIMER_W;
  localparam logic [TIMER_W-1:0] RUN_TERM  = TIMER_W'(RUN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STOP_TERM = TIMER_W'(STOP_HOLD - 1);

  // Reject parameter values the counter cannot represent.
  generate
    if (RUN_TIMEOUT < 2 || 64'(RUN_TIMEOUT) >= TIMER_SPAN) begin : g_bad_run_timeout
      $error("fsm_ctrl_timed: RUN_TIMEOUT out of range");
    end
    if (STOP_HOLD == 0 || 64'(STOP_HOLD) >= TIMER_SPAN) begin : g_bad_stop_hold
      $error("fsm_ctrl_timed: STOP_HOLD out of range");
    end
  endgenerate

  state_t             r_state;
  logic               r_busy;
  logic               r_timeout_flag;
  state_t             w_state_nxt;
  logic               w_tflag_nxt;
  logic               w_tmr_clr;
  logic               w_tmr_en;
  logic               w_at_term;
  logic               w_ready;
  logic               w_accept;
  cmd_t               w_cmd;
  logic [TIMER_W-1:0] w_term;

  assign w_ready  = (r_state == IDLE) || (r_state == RUN);
  assign w_accept = bus.cmd_valid && w_ready;
  assign w_cmd    = cmd_t'(bus.cmd);
  assign w_term   = (r_state == STOP) ? STOP_TERM : RUN_TERM;

  fsm_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clr       (w_tmr_clr),
    .i_en        (w_tmr_en),
    .i_term      (w_term),
    .o_at_term_c (w_at_term)
  );

  // State and status registers; status tracks the next state so it lines up with state_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_busy         <= (w_state_nxt == RUN) || (w_state_nxt == STOP);
      r_timeout_flag <= w_tflag_nxt;
    end
  end

  // Next state and timer control. RUN priority: ABORT > STOP > restart > expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_tflag_nxt = r_timeout_flag;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        w_tmr_clr = 1'b1;
        if (w_accept && w_cmd == CMD_RUN) begin
          w_state_nxt = RUN;
        end else if (w_accept && w_cmd == CMD_ABORT) begin
          w_state_nxt = FAULT;
          w_tflag_nxt = 1'b0;
        end
      end
      RUN: begin
        if (w_accept && w_cmd == CMD_ABORT) begin
          w_state_nxt = FAULT;
          w_tflag_nxt = 1'b0;
          w_tmr_clr   = 1'b1;
        end else if (w_accept && w_cmd == CMD_STOP) begin
          w_state_nxt = STOP;
          w_tmr_clr   = 1'b1;
        end else if (bus.heartbeat || (w_accept && w_cmd == CMD_RUN)) begin
          w_tmr_clr   = 1'b1;
        end else if (w_at_term) begin
          w_state_nxt = FAULT;
          w_tflag_nxt = 1'b1;
          w_tmr_clr   = 1'b1;
        end else begin
          w_tmr_en    = 1'b1;
        end
      end
      STOP: begin
        if (w_at_term) begin
          w_state_nxt = IDLE;
          w_tmr_clr   = 1'b1;
        end else begin
          w_tmr_en    = 1'b1;
        end
      end
      FAULT: begin
        w_tmr_clr = 1'b1;
        if (bus.fault_clr) begin
          w_state_nxt = IDLE;
          w_tflag_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tflag_nxt = 1'b0;
        w_tmr_clr   = 1'b1;
      end
    endcase
  end

  assign bus.cmd_ready    = w_ready;
  assign bus.state_out    = r_state;
  assign bus.busy         = r_busy;
  assign bus.timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_fsm_ctrl_timed.sv
// Directed bench for fsm_ctrl_timed with RUN_TIMEOUT=8, STOP_HOLD=3, 10 ns clock.
module tb_fsm_ctrl_timed;
  import fsm_ctrl_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  fsm_ctrl_timed_if bus ();

  fsm_ctrl_timed #(
    .TIMER_W     (16),
    .RUN_TIMEOUT (8),
    .STOP_HOLD   (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; sampling happens 1 ns after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
    bus.heartbeat = 1'b0;
    bus.fault_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick(2);
    checks++; if (bus.state_out !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", bus.state_out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.timeout_flag !== 1'b0) begin failures++; $display("FAIL reset_tflag got=%b exp=0", bus.timeout_flag); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_basic_cycle();
    bus.cmd_valid = 1'b1; bus.cmd = CMD_RUN;
    tick(1);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.state_out !== 2'b01) begin failures++; $display("FAIL basic_run_entry got=%b exp=01", bus.state_out); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_run_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL basic_run_ready got=%b exp=1", bus.cmd_ready); end
    // Heartbeat every 4th cycle keeps the watchdog at most at 3.
    for (int i = 0; i < 12; i++) begin
      bus.heartbeat = ((i % 4) == 3);
      tick(1);
      checks++; if (bus.state_out !== 2'b01) begin failures++; $display("FAIL basic_hb_run cyc=%0d got=%b exp=01", i, bus.state_out); end
    end
    bus.heartbeat = 1'b0;
    // STOP stays asserted through the whole drain; it must not be taken in STOP.
    bus.cmd_valid = 1'b1; bus.cmd = CMD_STOP;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++; if (bus.state_out !== 2'b10) begin failures++; $display("FAIL basic_stop cyc=%0d got=%b exp=10", k, bus.state_out); end
      checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL basic_stop_ready cyc=%0d got=%b exp=0", k, bus.cmd_ready); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_stop_busy cyc=%0d got=%b exp=1", k, bus.busy); end
    end
    tick(1);
    checks++; if (bus.state_out !== 2'b00) begin failures++; $display("FAIL basic_back_idle got=%b exp=00", bus.state_out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", bus.busy); end
    tick(1);
    checks++; if (bus.state_out !== 2'b00) begin failures++; $display("FAIL basic_stop_in_idle got=%b exp=00", bus.state_out); end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    bus.cmd_valid = 1'b1; bus.cmd = CMD_RUN;
    tick(1);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick(1);
      checks++; if (bus.state_out !== 2'b01) begin failures++; $display("FAIL wd_run cyc=%0d got=%b exp=01", k, bus.state_out); end
    end
    tick(1);
    checks++; if (bus.state_out !== 2'b11) begin failures++; $display("FAIL wd_fault got=%b exp=11", bus.state_out); end
    checks++; if (bus.timeout_flag !== 1'b1) begin failures++; $display("FAIL wd_tflag got=%b exp=1", bus.timeout_flag); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wd_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL wd_ready got=%b exp=0", bus.cmd_ready); end
    // FAULT is latched: a RUN command is not taken.
    bus.cmd_valid = 1'b1; bus.cmd = CMD_RUN;
    tick(2);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.state_out !== 2'b11) begin failures++; $display("FAIL wd_hold got=%b exp=11", bus.state_out); end
    checks++; if (bus.timeout_flag !== 1'b1) begin failures++; $display("FAIL wd_hold_tflag got=%b exp=1", bus.timeout_flag); end
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    checks++; if (bus.state_out !== 2'b00) begin failures++; $display("FAIL wd_clr got=%b exp=00", bus.state_out); end
    checks++; if (bus.timeout_flag !== 1'b0) begin failures++; $display("FAIL wd_clr_tflag got=%b exp=0", bus.timeout_flag); end
  endtask

  task automatic test_race();
    bus.cmd_valid = 1'b1; bus.cmd = CMD_RUN;
    tick(1);
    bus.cmd_valid = 1'b0;
    tick(7);
    // Timer is now 7: heartbeat on the expiry cycle wins.
    bus.heartbeat = 1'b1;
    tick(1);
    bus.heartbeat = 1'b0;
    checks++; if (bus.state_out !== 2'b01) begin failures++; $display("FAIL race_hb got=%b exp=01", bus.state_out); end
    checks++; if (bus.timeout_flag !== 1'b0) begin failures++; $display("FAIL race_hb_tflag got=%b exp=0", bus.timeout_flag); end
    tick(7);
    checks++; if (bus.state_out !== 2'b01) begin failures++; $display("FAIL race_pre_stop got=%b exp=01", bus.state_out); end
    // Timer is 7 again: STOP on the expiry cycle wins.
    bus.cmd_valid = 1'b1; bus.cmd = CMD_STOP;
    tick(1);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.state_out !== 2'b10) begin failures++; $display("FAIL race_stop got=%b exp=10", bus.state_out); end
    checks++; if (bus.timeout_flag !== 1'b0) begin failures++; $display("FAIL race_stop_tflag got=%b exp=0", bus.timeout_flag); end
    tick(3);
    checks++; if (bus.state_out !== 2'b00) begin failures++; $display("FAIL race_drain_idle got=%b exp=00", bus.state_out); end
  endtask

  task automatic test_abort();
    bus.cmd_valid = 1'b1; bus.cmd = CMD_ABORT;
    tick(1);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.state_out !== 2'b11) begin failures++; $display("FAIL abort_idle got=%b exp=11", bus.state_out); end
    checks++; if (bus.timeout_flag !== 1'b0) begin failures++; $display("FAIL abort_idle_tflag got=%b exp=0", bus.timeout_flag); end
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    checks++; if (bus.state_out !== 2'b00) begin failures++; $display("FAIL abort_idle_clr got=%b exp=00", bus.state_out); end
    bus.cmd_valid = 1'b1; bus.cmd = CMD_RUN;
    tick(1);
    bus.cmd_valid = 1'b0;
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    checks++; if (bus.state_out !== 2'b01) begin failures++; $display("FAIL abort_clr_in_run got=%b exp=01", bus.state_out); end
    bus.cmd_valid = 1'b1; bus.cmd = CMD_ABORT; bus.heartbeat = 1'b1;
    tick(1);
    idle_inputs();
    checks++; if (bus.state_out !== 2'b11) begin failures++; $display("FAIL abort_run got=%b exp=11", bus.state_out); end
    checks++; if (bus.timeout_flag !== 1'b0) begin failures++; $display("FAIL abort_run_tflag got=%b exp=0", bus.timeout_flag); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_run_busy got=%b exp=0", bus.busy); end
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    checks++; if (bus.state_out !== 2'b00) begin failures++; $display("FAIL abort_run_clr got=%b exp=00", bus.state_out); end
  endtask

  task automatic test_async_reset();
    // Mid-STOP with the drain timer at 1.
    bus.cmd_valid = 1'b1; bus.cmd = CMD_RUN;
    tick(1);
    bus.cmd = CMD_STOP;
    tick(1);
    bus.cmd_valid = 1'b0;
    tick(1);
    checks++; if (bus.state_out !== 2'b10) begin failures++; $display("FAIL ar_pre_stop got=%b exp=10", bus.state_out); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.state_out !== 2'b00) begin failures++; $display("FAIL ar_stop_state got=%b exp=00", bus.state_out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ar_stop_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL ar_stop_ready got=%b exp=1", bus.cmd_ready); end
    tick(1);
    reset_n = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd = CMD_RUN;
    tick(1);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.state_out !== 2'b01) begin failures++; $display("FAIL ar_stop_rerun got=%b exp=01", bus.state_out); end
    // Drive into a watchdog FAULT, then reset mid-FAULT.
    tick(8);
    checks++; if (bus.timeout_flag !== 1'b1) begin failures++; $display("FAIL ar_pre_fault_tflag got=%b exp=1", bus.timeout_flag); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.state_out !== 2'b00) begin failures++; $display("FAIL ar_fault_state got=%b exp=00", bus.state_out); end
    checks++; if (bus.timeout_flag !== 1'b0) begin failures++; $display("FAIL ar_fault_tflag got=%b exp=0", bus.timeout_flag); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL ar_fault_ready got=%b exp=1", bus.cmd_ready); end
    tick(1);
    reset_n = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd = CMD_RUN;
    tick(1);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.state_out !== 2'b01) begin failures++; $display("FAIL ar_fault_rerun got=%b exp=01", bus.state_out); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ar_fault_rerun_busy got=%b exp=1", bus.busy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_cycle();
    test_watchdog();
    test_race();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
